// File: rtl/dma_copy_engine.sv
// dma_copy_engine: word-at-a-time memory-to-memory copy engine on the controller's DMA port
module dma_copy_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [LEN_WIDTH-1:0]  words_done,
  output logic                  mem_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_valid
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] src, dst;
  logic [LEN_WIDTH-1:0] rem;
  logic [TW-1:0] tcnt;
  logic waiting, expired, last;
  assign waiting = state == RD_WAIT || state == WR_WAIT;
  assign expired = waiting && !mem_valid && tcnt == TW'(TIMEOUT - 1);
  assign last = rem == LEN_WIDTH'(1);
  assign busy = state != IDLE;
  assign done = state == FINISH;
  assign mem_en = state == RD_REQ || state == WR_REQ;
  assign mem_wr_en = state == WR_REQ;
  // next state: one request pulse, then wait for its completion or the timeout
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? (length != '0 ? RD_REQ : FINISH) : IDLE;
      RD_REQ:  state_nx = RD_WAIT;
      RD_WAIT: state_nx = mem_valid ? WR_REQ : expired ? FINISH : RD_WAIT;
      WR_REQ:  state_nx = WR_WAIT;
      WR_WAIT: state_nx = mem_valid ? (last ? FINISH : RD_REQ) : expired ? FINISH : WR_WAIT;
      default: state_nx = IDLE;
    endcase
  end
  // state, config latch, wait timer and the request address/data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      src        <= '0;
      dst        <= '0;
      rem        <= '0;
      tcnt       <= '0;
      err        <= 1'b0;
      words_done <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state <= state_nx;
      tcnt  <= waiting ? tcnt + TW'(1) : '0;
      if (expired) err <= 1'b1;
      if (state == IDLE && start) begin
        err        <= 1'b0;
        words_done <= '0;
        if (length != '0) begin
          src      <= src_addr;
          dst      <= dst_addr;
          rem      <= length;
          mem_addr <= src_addr;
        end
      end
      if (state == RD_WAIT && mem_valid) begin
        mem_wdata <= mem_rdata;
        mem_addr  <= dst;
      end
      if (state == WR_WAIT && mem_valid) begin
        src        <= src + ADDR_WIDTH'(1);
        dst        <= dst + ADDR_WIDTH'(1);
        rem        <= rem - LEN_WIDTH'(1);
        words_done <= words_done + LEN_WIDTH'(1);
        if (!last) mem_addr <= src + ADDR_WIDTH'(1);
      end
    end
  end
endmodule

// File: doc/dma_copy_engine.md
# dma_copy_engine

- Memory-to-memory copy engine that sits directly upstream of `memory_controller` on its DMA port.
- Software programs a source address, a destination address and a word count, then pulses `start`.
- The engine copies one word at a time: it issues a read request, waits for the returned data, then issues a write request with that data.
- It tolerates arbitration delay on the DMA port, since DMA is the lowest-priority, buffered requester.

## Interface

Parameters:
- `DATA_WIDTH`, default 32, memory word width.
- `ADDR_WIDTH`, default 16, word address width.
- `LEN_WIDTH`, default 16, width of the word-count register.
- `TIMEOUT`, default 64, maximum cycles to wait for `mem_valid` before flagging an error.

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle command pulse; ignored while `busy`.
- `src_addr`  in  ADDR_WIDTH  first source word address; sampled with `start`.
- `dst_addr`  in  ADDR_WIDTH  first destination word address; sampled with `start`.
- `length`  in  LEN_WIDTH  words to copy; sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  sticky timeout flag; cleared by `rst` or the next accepted `start`.
- `words_done`  out  LEN_WIDTH  count of completed word writes in the current or last transfer.
- `mem_en`  out  1  request strobe to the controller's DMAEn.
- `mem_wr_en`  out  1  write select to DMAWrEn.
- `mem_addr`  out  ADDR_WIDTH  to DMAAddr.
- `mem_wdata`  out  DATA_WIDTH  to DMAData.
- `mem_rdata`  in  DATA_WIDTH  from DMAOut.
- `mem_valid`  in  1  from DMAValid; completion of the outstanding request.

## Operation

FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH.

- **IDLE**
  - `start` with `length != 0`: latch `src_addr`, `dst_addr`, `length`; clear `words_done` and `err`; go to RD_REQ.
  - `start` with `length == 0`: go to FINISH; no memory access; `err` cleared.
- **RD_REQ** (one cycle)
  - Drives `mem_en=1`, `mem_wr_en=0`, `mem_addr=src`.
  - Always goes to RD_WAIT.
- **RD_WAIT**
  - `mem_en=0`.
  - On `mem_valid`: capture `mem_rdata` into the data register, go to WR_REQ.
- **WR_REQ** (one cycle)
  - Drives `mem_en=1`, `mem_wr_en=1`, `mem_addr=dst`, `mem_wdata`=captured data.
  - Goes to WR_WAIT.
- **WR_WAIT**
  - `mem_en=0`.
  - On `mem_valid`: `src+1`, `dst+1`, `remaining-1`, `words_done+1`.
  - If `remaining` becomes 0, go to FINISH; else go to RD_REQ.
- **FINISH**: `done=1` for one cycle, then IDLE.

Request and response rules:
- A request is exactly a one-cycle `mem_en` pulse. The controller captures and buffers it.
- At most one request is outstanding.
- `mem_valid` is ignored in IDLE, RD_REQ, WR_REQ and FINISH (it is stale there).

Arithmetic:
- Addresses increment modulo 2^ADDR_WIDTH: 0xFFFF wraps to 0x0000 with no error.
- Source and destination ranges may overlap; the copy proceeds in ascending order with no hazard check.

Timeout:
- A counter runs in RD_WAIT and WR_WAIT and reloads on entry to each wait state.
- If it reaches `TIMEOUT` cycles without `mem_valid`: set `err`, abort to FINISH (`done` still pulses).
- `words_done` keeps its partial count.

Ignored or overriding inputs:
- `start` in any state other than IDLE is ignored. Config registers are not modified.
- `rst` mid-transfer: the next cycle is IDLE, no further `mem_en`. A buffered request already in the controller is not recalled.

Output values:
- Outputs are registered, or decoded purely from the state register.
- Reset values: `busy=0`, `done=0`, `err=0`, `words_done=0`, `mem_en=0`, `mem_wr_en=0`, `mem_addr=0`, `mem_wdata=0`.
- `mem_addr` and `mem_wdata` hold their last values when `mem_en=0`.

## Timing

- `start` sampled at edge E → `busy=1` and RD_REQ (`mem_en=1`) in cycle E+1.
- Controller latency is 1 cycle (`mem_valid` in the cycle after the request). Per word:
  - RD_REQ cycle c.
  - Read `mem_valid` in cycle c+1.
  - WR_REQ cycle c+2.
  - Write `mem_valid` in cycle c+3.
  - Next RD_REQ cycle c+4.
  - Throughput is 4 cycles/word.
- Each additional cycle of controller delay adds one cycle in the corresponding wait state.
- Last write `mem_valid` in cycle t → FINISH in t+1 (`done=1`, `busy=1`) → IDLE in t+2 (`busy=0`).
- A new `start` is accepted in the cycle after `done`.
- N-word transfer at 1-cycle latency: `done` in cycle E+1+4N, with `length=0` giving `done` in cycle E+1.

## Test plan

1. **Basic copy.** Preload memory 0x0100..0x0103 = A0,A1,A2,A3. Start src=0x0100, dst=0x0200, len=4.
   - Expect 0x0200..0x0203 = A0..A3.
   - Expect `words_done=4`, `done` exactly 16 cycles after `busy` rises, `err=0`.
2. **Zero length.** Start with len=0.
   - Expect no `mem_en` ever.
   - Expect `done` pulse in cycle E+1, `words_done=0`.
3. **Arbitration stall.** Bench delays each `mem_valid` by 3 extra cycles.
   - Expect a single `mem_en` pulse per request, data correct.
   - Expect 10 cycles/word, `err=0`.
4. **Address wrap.** Start src=0xFFFE, dst=0x7FFE, len=4.
   - Expect reads at 0xFFFE, 0xFFFF, 0x0000, 0x0001 and writes at 0x7FFE..0x8001.
5. **Timeout.** Bench never answers the second read; `TIMEOUT`=64.
   - Expect `err=1` 64 cycles into RD_WAIT, `done` pulse, `words_done=1`, no further `mem_en`.
   - Expect the next `start` to clear `err`.
6. **Reset and busy-start.** Pulse `start` mid-transfer.
   - Expect it ignored and config unchanged.
   - Then assert `rst` during WR_WAIT: next cycle all outputs at reset values, FSM in IDLE.
